// File: rtl/modular_addition_pipe.sv
// Two-stage pipelined modular adder z = (x + y) mod M with valid/ready flow control.
// Define MODADD_RANGE_CHECK_EN to flag non-canonical operands on range_err.
module modular_addition_pipe #(
  parameter int data_width = 14,
  parameter int M          = 3329
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] x_add,
  input  logic [data_width-1:0] y_add,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] z_add,
  output logic                  range_err
);

  localparam int SW = data_width + 1;
  localparam logic [SW-1:0] M_W = SW'(M);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // a stage advances when it is empty or the stage after it advances.
  logic s1_en, s2_en, in_xfer;
  logic s1_valid_q, s2_valid_q;
  logic [SW-1:0] s1_sum_q, s1_sum_d, s1_red;
  logic [data_width-1:0] s2_q, s2_d;

  assign s2_en    = !s2_valid_q | out_ready;
  assign s1_en    = !s1_valid_q | s2_en;
  assign in_ready = s1_en & !rst;
  assign in_xfer  = in_valid & in_ready;

  assign s1_sum_d = {1'b0, x_add} + {1'b0, y_add};
  assign s1_red   = s1_sum_q - M_W;
  assign s2_d     = (s1_sum_q >= M_W) ? s1_red[data_width-1:0] : s1_sum_q[data_width-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_q       <= '0;
    end else begin
      if (s1_en) s1_valid_q <= in_xfer;
      if (in_xfer) s1_sum_q <= s1_sum_d;
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s2_en & s1_valid_q) s2_q <= s2_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign z_add     = s2_q;

`ifdef MODADD_RANGE_CHECK_EN
  // The error bit travels alongside its sum so it lines up with z_add.
  logic err1_q, err1_d, err2_q;

  assign err1_d = ({1'b0, x_add} >= M_W) | ({1'b0, y_add} >= M_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      if (in_xfer) err1_q <= err1_d;
      if (s2_en & s1_valid_q) err2_q <= err1_q;
    end
  end

  assign range_err = err2_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
